// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and round-robin helpers for the RAM-port arbiter.
package mem_arb_pkg;

  localparam int NPORTS_DEF  = 3;
  localparam int ADDR_W_DEF  = 27;
  localparam int PORT_ICACHE = 0;
  localparam int PORT_DCACHE = 1;
  localparam int PORT_DMA    = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  // Fold a 0..5 sum back into the 0..2 port range.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  function automatic logic [1:0] next_rr(input logic [1:0] idx);
    return wrap3({1'b0, idx} + 3'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// Combinational round-robin picker over three request slots.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] rr,
  output logic [1:0] grant_idx,
  output logic       any
);

  logic [1:0] w_idx;

  // Scan from the farthest candidate back to rr so the closest valid slot wins.
  always_comb begin
    grant_idx = 2'd0;
    w_idx     = 2'd0;
    any       = |valid;
    for (int i = 2; i >= 0; i--) begin
      w_idx = wrap3({1'b0, rr} + 3'(i));
      if (valid[w_idx]) grant_idx = w_idx;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Per-beat round-robin arbiter sharing one RAM port between icache, dcache and DMA,
// with completion routing and post-DMA-write line invalidation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS   = NPORTS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DMA_PORT = PORT_DMA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        c_req,
  input  logic [NPORTS-1:0]        c_we,
  input  logic [4*NPORTS-1:0]      c_be,
  input  logic [ADDR_W*NPORTS-1:0] c_addr,
  input  logic [32*NPORTS-1:0]     c_wdata,
  output logic [31:0]              c_rdata,
  output logic [NPORTS-1:0]        c_ready,
  output logic [NPORTS-1:0]        c_busy,
  output logic [NPORTS-1:0]        c_oob,
  input  logic [1:0]               cache_idle,
  output logic                     inv_valid,
  output logic [ADDR_W-1:0]        inv_addr,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready,
  input  logic                     mem_busy,
  input  logic                     mem_error_oob
);

  arb_state_t                    r_state, w_state_nxt;
  logic [NPORTS-1:0]             r_slot_vld, r_slot_we;
  logic [NPORTS-1:0][3:0]        r_slot_be;
  logic [NPORTS-1:0][ADDR_W-1:0] r_slot_addr;
  logic [NPORTS-1:0][31:0]       r_slot_wdata;
  logic [1:0]                    r_rr, r_owner;
  logic                          r_mem_req, r_mem_we;
  logic [3:0]                    r_mem_be;
  logic [ADDR_W-1:0]             r_mem_addr;
  logic [31:0]                   r_mem_wdata;
  logic [31:0]                   r_rdata;
  logic [NPORTS-1:0]             r_ready, r_oob;
  logic                          r_inv_valid;
  logic [ADDR_W-1:0]             r_inv_addr;

  logic [NPORTS-1:0] w_inflight, w_accept, w_busy;
  logic [1:0]        w_gidx;
  logic              w_any, w_grant, w_done, w_inv_set, w_inv_clr;

  rr_pick3 u_pick (
    .valid     (r_slot_vld),
    .rr        (r_rr),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  // A pulse landing on a full slot or an in-flight port is dropped outright.
  always_comb begin
    w_inflight = '0;
    w_accept   = '0;
    w_busy     = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_inflight[p] = (r_state == ARB_WAIT) && (r_owner == 2'(p));
      w_accept[p]   = c_req[p] && !r_slot_vld[p] && !w_inflight[p];
      w_busy[p]     = r_slot_vld[p] || w_inflight[p] || ((p == DMA_PORT) && r_inv_valid);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: if (w_any && !mem_busy) begin
        w_grant     = 1'b1;
        w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: if (mem_ready) begin
        w_done      = 1'b1;
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_inv_set = w_done && (r_owner == 2'(DMA_PORT)) && r_mem_we;
  assign w_inv_clr = r_inv_valid && (cache_idle == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_vld   <= '0;
      r_slot_we    <= '0;
      r_slot_be    <= '0;
      r_slot_addr  <= '0;
      r_slot_wdata <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (w_accept[p]) begin
          r_slot_vld[p]   <= 1'b1;
          r_slot_we[p]    <= c_we[p];
          r_slot_be[p]    <= c_be[4*p +: 4];
          r_slot_addr[p]  <= c_addr[ADDR_W*p +: ADDR_W];
          r_slot_wdata[p] <= c_wdata[32*p +: 32];
        end else if (w_grant && (w_gidx == 2'(p))) begin
          r_slot_vld[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr        <= 2'd0;
      r_owner     <= 2'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_ready     <= '0;
      r_oob       <= '0;
      r_inv_valid <= 1'b0;
      r_inv_addr  <= '0;
    end else begin
      r_mem_req <= w_grant;
      r_ready   <= '0;
      r_oob     <= '0;
      if (w_grant) begin
        r_mem_we    <= r_slot_we[w_gidx];
        r_mem_be    <= r_slot_be[w_gidx];
        r_mem_addr  <= r_slot_addr[w_gidx];
        r_mem_wdata <= r_slot_wdata[w_gidx];
        r_owner     <= w_gidx;
        r_rr        <= next_rr(w_gidx);
      end
      if (w_done) begin
        r_rdata          <= mem_rdata;
        r_ready[r_owner] <= 1'b1;
        r_oob[r_owner]   <= mem_error_oob;
      end
      // mem_addr still holds the completed beat's address here.
      if (w_inv_set) begin
        r_inv_valid <= 1'b1;
        r_inv_addr  <= r_mem_addr;
      end else if (w_inv_clr) begin
        r_inv_valid <= 1'b0;
      end
    end
  end

  assign c_rdata   = r_rdata;
  assign c_ready   = r_ready;
  assign c_oob     = r_oob;
  assign c_busy    = w_busy;
  assign inv_valid = r_inv_valid;
  assign inv_addr  = r_inv_addr;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-programmable RAM model.
module tb_mem_arbiter;

  localparam logic [26:0] OOB_LIM = 27'h4000000;

  logic        clk, rst;
  logic [2:0]  c_req, c_we, c_ready, c_busy, c_oob;
  logic [11:0] c_be;
  logic [80:0] c_addr;
  logic [95:0] c_wdata;
  logic [31:0] c_rdata, mem_wdata, mem_rdata;
  logic [1:0]  cache_idle;
  logic        inv_valid, mem_req, mem_we, mem_ready, mem_busy, mem_error_oob;
  logic [26:0] inv_addr, mem_addr;
  logic [3:0]  mem_be;

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  be;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        oob;
  } exp_t;

  exp_t exp_q[$];
  exp_t iss_q[$];
  int   n_tests = 0, n_fail = 0;
  int   lat, cnt;
  logic [26:0] m_addr;
  logic        m_we;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready), .c_busy(c_busy), .c_oob(c_oob),
    .cache_idle(cache_idle), .inv_valid(inv_valid), .inv_addr(inv_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_busy(mem_busy), .mem_error_oob(mem_error_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [26:0] a);
    if (a == 27'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic drv(input int p, input logic we, input logic [3:0] be,
                     input logic [26:0] a, input logic [31:0] wd);
    exp_t e;
    c_req[p]         = 1'b1;
    c_we[p]          = we;
    c_be[4*p +: 4]   = be;
    c_addr[27*p +: 27] = a;
    c_wdata[32*p +: 32] = wd;
    e.port = p; e.we = we; e.be = be; e.addr = a; e.wdata = wd;
    e.rdata = we ? 32'h0 : rd_fn(a);
    e.oob   = (a >= OOB_LIM);
    exp_q.push_back(e);
    iss_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    c_req = '0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("drain_timeout", 64'(exp_q.size() + iss_q.size()), 0);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ctl"}, {c_ready, c_busy, c_oob, inv_valid, mem_req, mem_we, mem_be}, 0);
    chk({pfx, "_dat"}, {mem_addr, c_rdata}, 0);
    chk({pfx, "_dat2"}, {mem_wdata, inv_addr}, 0);
  endtask

  // Monitor: downstream issue order, completion latency and routed results.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!rst) begin
      if (mem_req) begin
        if (iss_q.size() == 0) chk("iss_unexp", 64'(mem_req), 0);
        else begin
          e = iss_q.pop_front();
          chk("iss_addr", 64'(mem_addr), 64'(e.addr));
          chk("iss_we", 64'(mem_we), 64'(e.we));
          chk("iss_be", 64'(mem_be), 64'(e.be));
          if (e.we) chk("iss_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end
      if (c_ready != 0 || mem_ready) chk("rdy_lat", 64'(c_ready != 0), 64'(mem_ready));
      if ((c_oob & ~c_ready) != 0) chk("oob_align", 64'(c_oob & ~c_ready), 0);
      for (int p = 0; p < 3; p++) begin
        if (c_ready[p]) begin
          k = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (k < 0 && exp_q[i].port == p) k = i;
          if (k < 0) chk("rdy_unexp", 64'(c_ready[p]), 0);
          else begin
            chk("rdata", 64'(c_rdata), 64'(exp_q[k].rdata));
            chk("oob", 64'(c_oob[p]), 64'(exp_q[k].oob));
            exp_q.delete(k);
          end
        end
      end
    end
  end

  // RAM model; runs just after the negedge so it sees that edge's stimulus.
  always @(negedge clk) begin
    #1;
    mem_ready     = 1'b0;
    mem_error_oob = 1'b0;
    if (rst) cnt = 0;
    else if (mem_req) begin
      cnt    = lat;
      m_addr = mem_addr;
      m_we   = mem_we;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_ready     = 1'b1;
        mem_rdata     = m_we ? 32'h0 : rd_fn(m_addr);
        mem_error_oob = (m_addr >= OOB_LIM);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int g, n, nrdy;
    rst = 1'b1; c_req = '0; c_we = '0; c_be = '0; c_addr = '0; c_wdata = '0;
    cache_idle = 2'b11; mem_busy = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    mem_error_oob = 1'b0; lat = 2; cnt = 0; m_addr = '0; m_we = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single read with minimum-latency issue
    lat = 3;
    drv(1, 1'b0, 4'hF, 27'h40, 32'h0);
    tick();
    chk("s1_noreq", 64'(mem_req), 0);
    chk("s1_busy", 64'(c_busy), 64'(3'b010));
    @(negedge clk);
    chk("s1_req", 64'(mem_req), 1);
    wait_idle(40);
    chk("s1_rdata", 64'(c_rdata), 64'h0DEADBEEF);
    chk("s1_idle_busy", 64'(c_busy), 0);

    // Port 2 read moves rr to 0, then three-way contention
    drv(2, 1'b0, 4'h3, 27'h1234, 32'h0);
    tick();
    wait_idle(40);
    lat = 1;
    drv(0, 1'b1, 4'hA, 27'h100, 32'hCAFEF00D);
    drv(1, 1'b0, 4'hF, 27'h204, 32'h0);
    drv(2, 1'b0, 4'hC, 27'h308, 32'h0);
    tick();
    chk("c3_busy", 64'(c_busy), 64'(3'b111));
    wait_idle(60);
    chk("c3_rr_end", 64'(dut.r_rr), 0);

    // Downstream busy stall
    lat = 2;
    mem_busy = 1'b1;
    drv(0, 1'b0, 4'hF, 27'h88, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", 64'(mem_req), 0);
      chk("stall_busy0", 64'(c_busy[0]), 1);
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("stall_grant", 64'(mem_req), 1);
    wait_idle(40);

    // DMA write invalidation, with a cache beat granted during it
    cache_idle = 2'b01;
    drv(2, 1'b1, 4'hF, 27'h0004000, 32'h12345678);
    tick();
    g = 0;
    while (!inv_valid && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("inv_rise", 64'(inv_valid), 1);
    chk("inv_with_ready", 64'(c_ready[2]), 1);
    chk("inv_addr", 64'(inv_addr), 64'(27'h0004000));
    chk("inv_busy2", 64'(c_busy[2]), 1);
    n = inv_valid ? 1 : 0;
    g = 0;
    while (n > 0 && g < 20) begin
      if (n == 1) drv(0, 1'b0, 4'hF, 27'h500, 32'h0);
      if (n == 5) cache_idle = 2'b11;
      @(negedge clk);
      c_req = '0;
      g++;
      if (!inv_valid) break;
      n++;
      chk("inv_busy2_hold", 64'(c_busy[2]), 1);
      chk("inv_addr_hold", 64'(inv_addr), 64'(27'h0004000));
    end
    chk("inv_len", 64'(n), 5);
    cache_idle = 2'b11;
    wait_idle(40);
    chk("inv_dma_free", 64'(c_busy[2]), 0);

    // Out-of-bounds read
    drv(0, 1'b0, 4'hF, 27'h7FFFFF0, 32'h0);
    tick();
    wait_idle(40);

    // Reset while a beat is in flight and port 2's slot is full
    lat = 6;
    drv(0, 1'b0, 4'hF, 27'h600, 32'h0);
    tick();
    @(negedge clk);
    drv(2, 1'b0, 4'hF, 27'h700, 32'h0);
    tick();
    chk("r6_busy", 64'(c_busy), 64'(3'b101));
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_zero("r6_reset");
    nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (c_ready != 0) nrdy++;
    end
    chk("r6_no_ready", 64'(nrdy), 0);
    lat = 2;
    drv(1, 1'b0, 4'hF, 27'h40, 32'h0);
    tick();
    wait_idle(40);
    chk("r6_after", 64'(c_rdata), 64'h0DEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
